multi_cycle_adder: RTL and testbench
====================================

MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits; legal range is 1 or more.
REQ-002 Parameter CHUNK, default 4, bits added per clock; legal range is 1..WIDTH, and WIDTH mod CHUNK shall be 0.
REQ-003 The block shall have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-007 a  input  WIDTH  operand A; latched when start is accepted.
REQ-008 b  input  WIDTH  operand B; latched when start is accepted.
REQ-009 carry_in  input  1  carry into bit 0; latched when start is accepted.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 done  output  1  single-cycle pulse marking that a new result is valid.
REQ-012 sum  output  WIDTH  registered result, bits WIDTH-1..0 of a+b+carry_in.
REQ-013 carry_out  output  1  registered carry out of bit WIDTH-1.

Function
REQ-014 N = WIDTH/CHUNK; the chunk counter shall be ceil(log2(N)), with a minimum of 1 bit.
REQ-015 FSM states shall be IDLE, RUN and DONE; there is no other reachable state.
REQ-016 IDLE with start=1 at a rising edge shall latch a, b and carry_in into internal registers, clear the chunk index to 0 and go to RUN.
REQ-017 IDLE with start=0 shall stay in IDLE.
REQ-018 Each RUN edge shall compute chunk i as a_reg[i]+b_reg[i]+c_reg, where c_reg is carry_in for i=0.
REQ-019 Each RUN edge shall store the CHUNK-bit result into working-sum chunk i, store the chunk carry into c_reg and increment i.
REQ-020 On the RUN edge that processes chunk N-1, the block shall load sum and carry_out from the working sum and final carry, and go to DONE.
REQ-021 DONE shall assert done=1 for exactly one cycle, then return to IDLE on the next edge unconditionally.
REQ-022 Latency: if start is sampled at edge E0, busy shall be 1 after E0 through edge EN, sum and carry_out shall update at EN, and done shall be 1 between EN and EN+1.
REQ-023 With CHUNK=WIDTH (N=1), RUN shall last exactly one cycle.
REQ-024 start during RUN or DONE shall be ignored, with no queuing.
REQ-025 Changes on a, b or carry_in after acceptance shall not affect the result in progress.
REQ-026 sum and carry_out shall hold their last completed result until the next completion and shall never show partial values.
REQ-027 With start held high continuously, a new operation shall be accepted every N+2 edges, at the first IDLE edge after DONE.
REQ-028 Arithmetic shall be unsigned modulo 2^WIDTH, with overflow reported only on carry_out.

Reset
REQ-029 rst_n=0 shall immediately, without waiting for clk, force state to IDLE, busy=0, done=0, sum=0, carry_out=0, and clear the counter, c_reg and the working and operand registers to 0.
REQ-030 Reset asserted mid-RUN shall abandon the operation; no done pulse shall follow.
REQ-031 After release, the first rising edge with start=1 shall be accepted normally.
REQ-032 Reset deassertion is assumed synchronous to clk at system level, and no synchronizer is required inside the block.

Verification
REQ-033 With WIDTH=16 and CHUNK=4, applying a=16'hFFFF, b=16'h0001, carry_in=0 and pulsing start shall give sum=16'h0000, carry_out=1, with done exactly 4 edges after the start edge and busy high for 4 cycles.
REQ-034 With WIDTH=16 and CHUNK=4, applying a=16'h1234, b=16'h4321, carry_in=1 shall give sum=16'h5556, carry_out=0.
REQ-035 With WIDTH=4 and CHUNK=1, exhaustively applying all 512 combinations of a, b and carry_in shall give {carry_out,sum} equal to a+b+carry_in for every case, with done 4 edges after each start.
REQ-036 With WIDTH=8 and CHUNK=8, applying a=8'h80, b=8'h80, carry_in=1 shall give sum=8'h01, carry_out=1, done 1 edge after start, and busy high for exactly 1 cycle.
REQ-037 Start, then at 2 edges into RUN drive a and b to new values and pulse start again: the result shall match the original operands and exactly one done pulse shall occur.
REQ-038 Start, then drop rst_n low for half a cycle during RUN: all outputs shall read 0 immediately with no done pulse, and a subsequent start with a=16'h0003, b=16'h0004, carry_in=0 shall give sum=16'h0007.

Source files
------------

// File: rtl/multi_cycle_adder.sv
// -----------------------------------------------------------------------------
// multi_cycle_adder
//
// Adds two WIDTH-bit unsigned operands plus a carry-in by rippling CHUNK bits
// per clock through a small adder. The operands are captured when start is
// accepted in IDLE. The block then spends N = WIDTH/CHUNK cycles in RUN and
// one cycle in DONE. sum/carry_out change only on the final RUN edge, so they
// never show a partial result.
//
// Parameters
//   WIDTH : operand and sum width in bits (>= 1)
//   CHUNK : bits added per clock (1..WIDTH, WIDTH % CHUNK == 0)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request an addition (sampled only in IDLE)
//   a, b      in   WIDTH-bit operands, latched on accept
//   carry_in  in   carry into bit 0, latched on accept
//   busy      out  high while the adder is in RUN
//   done      out  one-cycle pulse: new sum/carry_out valid
//   sum       out  registered result bits WIDTH-1..0
//   carry_out out  registered carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               c_r;
    logic [CW-1:0]      idx_r;
    logic [WIDTH-1:0]   work_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;

    int                 base_s;
    logic [CHUNK-1:0]   chunk_a_s;
    logic [CHUNK-1:0]   chunk_b_s;
    logic [CHUNK:0]     chunk_res_s;
    logic [WIDTH-1:0]   work_nxt_s;
    logic               last_s;

    // Chunk datapath: select chunk idx_r, add it with the running carry and
    // merge the result into a copy of the working sum. The merged copy lets
    // the final edge load sum without waiting one more cycle for work_r.
    always_comb begin
        base_s      = int'(idx_r) * CHUNK;
        chunk_a_s   = a_r[base_s +: CHUNK];
        chunk_b_s   = b_r[base_s +: CHUNK];
        chunk_res_s = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{CHUNK{1'b0}}, c_r};
        work_nxt_s  = work_r;
        work_nxt_s[base_s +: CHUNK] = chunk_res_s[CHUNK-1:0];
        last_s      = (idx_r == CW'(N - 1));
    end

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered status flags that follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand capture, chunk iteration and result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            c_r    <= 1'b0;
            idx_r  <= {CW{1'b0}};
            work_r <= {WIDTH{1'b0}};
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        c_r   <= carry_in;
                        idx_r <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    work_r <= work_nxt_s;
                    c_r    <= chunk_res_s[CHUNK];
                    idx_r  <= idx_r + CW'(1);
                    if (last_s) begin
                        sum_r  <= work_nxt_s;
                        cout_r <= chunk_res_s[CHUNK];
                    end
                end
                default: begin
                    c_r <= c_r;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign sum       = sum_r;
    assign carry_out = cout_r;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_adder
//
// Directed, self-checking bench with three adder configurations:
//   u16 : WIDTH=16, CHUNK=4  (table of vectors plus corner sequences)
//   u4  : WIDTH=4,  CHUNK=1  (all 512 operand/carry combinations)
//   u8  : WIDTH=8,  CHUNK=8  (single-cycle RUN)
// Inputs are driven away from the rising edge and outputs are sampled 1 ns
// after it.
// -----------------------------------------------------------------------------
module tb_multi_cycle_adder;

    logic        clk;
    logic        rst_n;

    logic        s16_start, s16_cin, o16_busy, o16_done, o16_cout;
    logic [15:0] s16_a, s16_b, o16_sum;
    logic        s4_start, s4_cin, o4_busy, o4_done, o4_cout;
    logic [3:0]  s4_a, s4_b, o4_sum;
    logic        s8_start, s8_cin, o8_busy, o8_done, o8_cout;
    logic [7:0]  s8_a, s8_b, o8_sum;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[10];

    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16_start), .a(s16_a), .b(s16_b),
        .carry_in(s16_cin), .busy(o16_busy), .done(o16_done), .sum(o16_sum),
        .carry_out(o16_cout)
    );

    multi_cycle_adder #(.WIDTH(4), .CHUNK(1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .a(s4_a), .b(s4_b),
        .carry_in(s4_cin), .busy(o4_busy), .done(o4_done), .sum(o4_sum),
        .carry_out(o4_cout)
    );

    multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .a(s8_a), .b(s8_b),
        .carry_in(s8_cin), .busy(o8_busy), .done(o8_done), .sum(o8_sum),
        .carry_out(o8_cout)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run can never hang.
    initial begin
        #300000;
        $display("FAIL timeout global time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // One 16-bit operation: checks result, latency, busy length, result hold
    // while busy, operand isolation after accept and the one-cycle done pulse.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] xs, input logic xc);
        int          lat;
        int          bcnt;
        logic [15:0] prev;
        logic        held;
        @(negedge clk);
        s16_a = a; s16_b = b; s16_cin = cin; s16_start = 1'b1;
        prev = o16_sum;
        @(posedge clk); #1;
        s16_start = 1'b0;
        s16_a = ~a; s16_b = ~b; s16_cin = ~cin;
        lat  = 0;
        bcnt = o16_busy ? 1 : 0;
        held = (o16_sum === prev);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (o16_done) begin
                lat = k;
                break;
            end
            if (o16_busy) bcnt++;
            if (o16_sum !== prev) held = 1'b0;
        end
        chk("w16_sum", {16'h0000, o16_sum}, {16'h0000, xs});
        chk("w16_cout", {31'd0, o16_cout}, {31'd0, xc});
        chk("w16_latency", lat, 32'd4);
        chk("w16_busy_cycles", bcnt, 32'd4);
        chk("w16_sum_held_while_busy", {31'd0, held}, 32'd1);
        @(posedge clk); #1;
        chk("w16_done_one_cycle", {30'd0, o16_done, o16_busy}, 32'd0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int         lat;
        logic [4:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        @(negedge clk);
        s4_a = a; s4_b = b; s4_cin = c; s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (o4_done) begin
                lat = k;
                break;
            end
        end
        chk("w4_result", {27'd0, o4_cout, o4_sum}, {27'd0, exp});
        chk("w4_latency", lat, 32'd4);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        int first_k;
        int second_k;
        logic [16:0] got;

        checks = 0;
        errors = 0;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[5] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[9] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0};

        rst_n = 1'b0;
        s16_start = 1'b0; s16_a = 16'h0000; s16_b = 16'h0000; s16_cin = 1'b0;
        s4_start  = 1'b0; s4_a  = 4'h0;     s4_b  = 4'h0;     s4_cin  = 1'b0;
        s8_start  = 1'b0; s8_a  = 8'h00;    s8_b  = 8'h00;    s8_cin  = 1'b0;

        // Reset state, before any clock edge.
        #3;
        chk("reset_u16", {13'd0, o16_busy, o16_done, o16_cout, o16_sum}, 32'd0);
        chk("reset_u4",  {25'd0, o4_busy, o4_done, o4_cout, o4_sum}, 32'd0);
        chk("reset_u8",  {21'd0, o8_busy, o8_done, o8_cout, o8_sum}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table of 16-bit vectors.
        for (int i = 0; i < 10; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
        end

        // WIDTH=8, CHUNK=8: one RUN cycle.
        @(negedge clk);
        s8_a = 8'h80; s8_b = 8'h80; s8_cin = 1'b1; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        bcnt = o8_busy ? 1 : 0;
        lat  = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (o8_done) begin
                lat = k;
                break;
            end
            if (o8_busy) bcnt++;
        end
        chk("w8_result", {23'd0, o8_cout, o8_sum}, {23'd0, 1'b1, 8'h01});
        chk("w8_latency", lat, 32'd1);
        chk("w8_busy_cycles", bcnt, 32'd1);

        // Operand change and second start while RUN: ignored, one done pulse.
        @(negedge clk);
        s16_a = 16'h1111; s16_b = 16'h2222; s16_cin = 1'b0; s16_start = 1'b1;
        @(posedge clk); #1;
        s16_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s16_a = 16'hFFFF; s16_b = 16'hFFFF; s16_start = 1'b1;
        dcnt = 0;
        got  = 17'd0;
        for (int k = 3; k <= 14; k++) begin
            @(posedge clk); #1;
            s16_start = 1'b0;
            if (o16_done) begin
                dcnt++;
                got = {o16_cout, o16_sum};
            end
        end
        chk("ignore_start_done_count", dcnt, 32'd1);
        chk("ignore_start_result", {15'd0, got}, {15'd0, 17'h03333});

        // Back-to-back with start held high: accepts every N+2 = 6 edges.
        @(negedge clk);
        s16_a = 16'h0001; s16_b = 16'h0001; s16_cin = 1'b0; s16_start = 1'b1;
        first_k  = 0;
        second_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (o16_done) begin
                if (first_k == 0) first_k = k;
                else if (second_k == 0) second_k = k;
            end
        end
        s16_start = 1'b0;
        chk("b2b_first_done", first_k, 32'd5);
        chk("b2b_spacing", second_k - first_k, 32'd6);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_sum", {16'd0, o16_sum}, 32'h00000002);

        // Reset pulse mid-RUN.
        run16(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        @(negedge clk);
        s16_a = 16'h1111; s16_b = 16'h2222; s16_cin = 1'b0; s16_start = 1'b1;
        @(posedge clk); #1;
        s16_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrun_busy_before_reset", {31'd0, o16_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {13'd0, o16_busy, o16_done, o16_cout, o16_sum}, 32'd0);
        #4;
        rst_n = 1'b1;
        dcnt = 0;
        bcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (o16_done) dcnt++;
            if (o16_busy) bcnt++;
        end
        chk("midrun_no_done", dcnt, 32'd0);
        chk("midrun_no_busy", bcnt, 32'd0);
        run16(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

        // WIDTH=4, CHUNK=1: every a, b, carry_in combination.
        for (int i = 0; i < 512; i++) begin
            run4(i[3:0], i[7:4], i[8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
